// File: rtl/execute_stage_mdu.sv
// RISC-V execute stage: operand forwarding, ALU, branch/jump resolution,
// iterative RV32M multiply/divide unit with pipeline stall, and the EX/MEM register.
module execute_stage_mdu #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned MDU_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidE,
  input  logic            FlushE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            ALUSrcE,
  input  logic            BranchE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic [2:0]      BranchTypeE,
  input  logic [3:0]      ALUControlE,
  input  logic            MduE,
  input  logic [2:0]      MduOpE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [RA_W-1:0] RD_E,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            StallE,
  output logic            ValidM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [RA_W-1:0] RD_M,
  output logic [XLEN-1:0] ALU_ResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);
  localparam int unsigned SHW    = $clog2(XLEN);
  localparam int unsigned CW     = $clog2(XLEN) + 1;
  localparam bit          MDU_ON = (MDU_EN != 0);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_res, mdu_res, jalr_sum;
  logic [SHW-1:0]  shamt;
  logic            br_cond, is_m, mdu_start, stall_c, load_real;

  always_comb begin
    unique case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    unique case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;
  assign shamt = src_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (ALUControlE)
      4'd0:    alu_res = src_a + src_b;
      4'd1:    alu_res = src_a - src_b;
      4'd2:    alu_res = src_a & src_b;
      4'd3:    alu_res = src_a | src_b;
      4'd4:    alu_res = src_a ^ src_b;
      4'd5:    alu_res[0] = $signed(src_a) < $signed(src_b);
      4'd6:    alu_res[0] = src_a < src_b;
      4'd7:    alu_res = src_a << shamt;
      4'd8:    alu_res = src_a >> shamt;
      4'd9:    alu_res = $signed(src_a) >>> shamt;
      4'd10:   alu_res = src_b;
      default: alu_res = '0;
    endcase
  end

  // Branch compare always uses the register operand, never the immediate
  always_comb begin
    unique case (BranchTypeE)
      3'b000:  br_cond = (src_a == fwd_b);
      3'b001:  br_cond = (src_a != fwd_b);
      3'b100:  br_cond = $signed(src_a) < $signed(fwd_b);
      3'b101:  br_cond = $signed(src_a) >= $signed(fwd_b);
      3'b110:  br_cond = src_a < fwd_b;
      3'b111:  br_cond = src_a >= fwd_b;
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr_sum  = src_a + Imm_Ext_E;
  assign PCTargetE = JalrE ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0}) : (PCE + Imm_Ext_E);
  assign PCSrcE    = ValidE & ~FlushE & (JumpE | (BranchE & br_cond));

  // ---------------- Multiply / divide unit ----------------
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] acc_q, lo_q, b_q, a_raw_q, acc_d, lo_d;
  logic [2:0]      op_q;
  logic            neg_q, div0_q;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, quo, rem;
  logic [XLEN:0]   sum, shifted, diff;
  logic [2*XLEN-1:0] prod, prod_s;

  assign is_m      = MDU_ON && MduE;
  assign mdu_start = is_m && ValidE && !FlushE && (state_q == S_IDLE);
  assign stall_c   = ~rst & (mdu_start | ((state_q == S_BUSY) & ~FlushE));
  assign StallE    = stall_c;

  assign a_sgn = (MduOpE == 3'b001) || (MduOpE == 3'b010) || (MduOpE == 3'b100) || (MduOpE == 3'b110);
  assign b_sgn = (MduOpE == 3'b001) || (MduOpE == 3'b100) || (MduOpE == 3'b110);
  assign a_neg = a_sgn & src_a[XLEN-1];
  assign b_neg = b_sgn & fwd_b[XLEN-1];
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -fwd_b : fwd_b;

  // One shift-add (multiply) or restoring-subtract (divide) step on {acc, lo}
  always_comb begin
    sum     = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {acc_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, b_q};
    if (op_q[2]) begin
      acc_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_d  = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      acc_d = sum[XLEN:1];
      lo_d  = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod   = {acc_q, lo_q};
    prod_s = neg_q ? -prod : prod;
    quo    = neg_q ? -lo_q : lo_q;
    rem    = neg_q ? -acc_q : acc_q;
    unique case (op_q)
      3'b000:          mdu_res = prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          mdu_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:  mdu_res = div0_q ? '1 : quo;
      default:         mdu_res = div0_q ? a_raw_q : rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      a_raw_q <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else if (FlushE) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (mdu_start) begin
          acc_q   <= '0;
          lo_q    <= a_mag;
          b_q     <= b_mag;
          a_raw_q <= src_a;
          op_q    <= MduOpE;
          // Remainder takes the dividend's sign; everything else the XOR
          neg_q   <= (MduOpE[2] & MduOpE[1]) ? a_neg : (a_neg ^ b_neg);
          div0_q  <= (fwd_b == '0);
          cnt_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          acc_q <= acc_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // EX/MEM register: real instruction or an all-zero bubble every cycle
  assign load_real = ValidE & ~FlushE & ~stall_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ValidM      <= 1'b0;
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
      PCPlus4M    <= '0;
    end else if (load_real) begin
      ValidM      <= 1'b1;
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      ALU_ResultM <= is_m ? mdu_res : alu_res;
      WriteDataM  <= fwd_b;
      PCPlus4M    <= PCPlus4E;
    end else begin
      ValidM      <= 1'b0;
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
      PCPlus4M    <= '0;
    end
  end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Directed self-checking bench for execute_stage_mdu (XLEN=32).
module tb_execute_stage_mdu;
  logic        clk = 1'b0;
  logic        rst;
  logic        ValidE, FlushE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE;
  logic        BranchE, JumpE, JalrE, MduE;
  logic [2:0]  BranchTypeE, MduOpE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic        PCSrcE, StallE, ValidM, RegWriteM, MemWriteM, ResultSrcM;
  logic [31:0] PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RD_M;

  int checks = 0;
  int failures = 0;

  execute_stage_mdu #(.XLEN(32), .RA_W(5), .MDU_EN(1)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .ALUSrcE(ALUSrcE),
    .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .BranchTypeE(BranchTypeE),
    .ALUControlE(ALUControlE), .MduE(MduE), .MduOpE(MduOpE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallE(StallE),
    .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ValidE = 0; FlushE = 0; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; ALUSrcE = 0;
    BranchE = 0; JumpE = 0; JalrE = 0; MduE = 0; BranchTypeE = 0; MduOpE = 0;
    ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0;
    ResultW = 0; RD_E = 0; ForwardA_E = 0; ForwardB_E = 0;
  endtask

  task automatic test_reset();
    checks++; if (ValidM !== 1'b0) begin failures++; $display("FAIL reset_validm got=%0b exp=0", ValidM); end
    checks++; if (ALU_ResultM !== 32'h0) begin failures++; $display("FAIL reset_alu got=%h exp=0", ALU_ResultM); end
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", StallE); end
    checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL reset_pcsrc got=%0b exp=0", PCSrcE); end
  endtask

  task automatic test_add_fwd();
    clear_inputs();
    ValidE = 1; RegWriteE = 1; RD1_E = 5; ResultW = 7; ForwardA_E = 2'b01; RD2_E = 3;
    ALUControlE = 4'd0; RD_E = 5'd9; PCPlus4E = 32'h24;
    #1;
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL add_stall got=%0b exp=0", StallE); end
    tick();
    checks++; if (ALU_ResultM !== 32'd10) begin failures++; $display("FAIL add_fwd_result got=%h exp=0000000a", ALU_ResultM); end
    checks++; if (ValidM !== 1'b1 || RegWriteM !== 1'b1 || RD_M !== 5'd9 || PCPlus4M !== 32'h24) begin
      failures++; $display("FAIL add_fwd_ctrl got=v%0b w%0b rd%0d pc4=%h exp=v1 w1 rd9 pc4=24", ValidM, RegWriteM, RD_M, PCPlus4M);
    end
  endtask

  task automatic test_alu_ops();
    logic [3:0]  op [11];
    logic [31:0] a [11];
    logic [31:0] b [11];
    logic [31:0] e [11];
    op = '{4'd1, 4'd5, 4'd6, 4'd9, 4'd8, 4'd7, 4'd10, 4'd12, 4'd4, 4'd2, 4'd3};
    a  = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd1, 32'd5, 32'd5, 32'hF0, 32'hF0, 32'hF0};
    b  = '{32'd7, 32'd1, 32'd1, 32'd4, 32'd36, 32'd31, 32'h1234, 32'd5, 32'hFF, 32'h3C, 32'h0F};
    e  = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'h08000000, 32'h80000000, 32'h1234, 32'd0, 32'h0F, 32'h30, 32'hFF};
    clear_inputs();
    for (int i = 0; i < 11; i++) begin
      ValidE = 1; RegWriteE = 1; ALUControlE = op[i]; RD1_E = a[i]; RD2_E = b[i];
      tick();
      checks++;
      if (ALU_ResultM !== e[i]) begin
        failures++; $display("FAIL alu_op%0d got=%h exp=%h", op[i], ALU_ResultM, e[i]);
      end
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    ValidE = 1; BranchE = 1; BranchTypeE = 3'b100; RD1_E = 32'hFFFFFFFF; RD2_E = 1;
    PCE = 32'h100; Imm_Ext_E = 32'h20; ALUSrcE = 1;
    #1;
    checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'h120) begin
      failures++; $display("FAIL blt_taken got=%0b/%h exp=1/00000120", PCSrcE, PCTargetE);
    end
    BranchTypeE = 3'b110; #1;
    checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL bltu_not_taken got=%0b exp=0", PCSrcE); end
    BranchTypeE = 3'b010; RD2_E = 32'hFFFFFFFF; #1;
    checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL btype010 got=%0b exp=0", PCSrcE); end
    BranchTypeE = 3'b000; #1;
    checks++; if (PCSrcE !== 1'b1) begin failures++; $display("FAIL beq_taken got=%0b exp=1", PCSrcE); end
    FlushE = 1; #1;
    checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL branch_flush got=%0b exp=0", PCSrcE); end
    FlushE = 0; BranchE = 0; JumpE = 1; JalrE = 1; RD1_E = 32'h1001; Imm_Ext_E = 32'h10; #1;
    checks++; if (PCSrcE !== 1'b1 || PCTargetE !== 32'h1010) begin
      failures++; $display("FAIL jalr_target got=%0b/%h exp=1/00001010", PCSrcE, PCTargetE);
    end
    ValidE = 0; #1;
    checks++; if (PCSrcE !== 1'b0) begin failures++; $display("FAIL jump_invalid got=%0b exp=0", PCSrcE); end
    clear_inputs();
    tick();
  endtask

  task automatic test_mulh();
    int  cyc;
    bit  bubble_bad;
    clear_inputs();
    ValidE = 1; RegWriteE = 1; MduE = 1; MduOpE = 3'b001; RD1_E = 32'h80000000; RD2_E = 32'h80000000;
    RD_E = 5'd3;
    #1;
    cyc = 0; bubble_bad = 0;
    while (StallE === 1'b1 && cyc < 100) begin
      if (cyc > 0 && (ValidM !== 1'b0 || RegWriteM !== 1'b0)) bubble_bad = 1;
      cyc++;
      tick();
    end
    checks++; if (cyc != 33) begin failures++; $display("FAIL mulh_stall_cycles got=%0d exp=33", cyc); end
    checks++; if (bubble_bad) begin failures++; $display("FAIL mulh_bubbles got=valid_during_stall exp=bubble"); end
    tick();
    checks++; if (ALU_ResultM !== 32'h40000000 || RegWriteM !== 1'b1 || ValidM !== 1'b1 || RD_M !== 5'd3) begin
      failures++; $display("FAIL mulh_result got=%h w%0b v%0b rd%0d exp=40000000 w1 v1 rd3", ALU_ResultM, RegWriteM, ValidM, RD_M);
    end
    clear_inputs();
  endtask

  task automatic test_mdu_ops();
    logic [2:0]  op [11];
    logic [31:0] a [11];
    logic [31:0] b [11];
    logic [31:0] e [11];
    int cyc;
    op = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b100, 3'b110, 3'b000, 3'b011, 3'b010, 3'b101, 3'b111};
    a  = '{32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd3,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd100};
    b  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'hFFFFFFFC,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'd16, 32'd7};
    e  = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF4,
           32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'd2};
    clear_inputs();
    for (int i = 0; i < 11; i++) begin
      ValidE = 1; RegWriteE = 1; MduE = 1; MduOpE = op[i]; RD1_E = a[i]; RD2_E = b[i];
      #1;
      cyc = 0;
      while (StallE === 1'b1 && cyc < 100) begin
        cyc++;
        tick();
      end
      checks++; if (cyc != 33) begin failures++; $display("FAIL mdu%0d_stall_cycles got=%0d exp=33", i, cyc); end
      tick();
      checks++;
      if (ALU_ResultM !== e[i] || ValidM !== 1'b1) begin
        failures++; $display("FAIL mdu%0d_op%0d got=%h v%0b exp=%h v1", i, op[i], ALU_ResultM, ValidM, e[i]);
      end
      clear_inputs();
    end
  endtask

  task automatic test_flush_mid_div();
    clear_inputs();
    ValidE = 1; RegWriteE = 1; MduE = 1; MduOpE = 3'b100; RD1_E = 32'd100; RD2_E = 32'd7;
    #1;
    checks++; if (StallE !== 1'b1) begin failures++; $display("FAIL div_start_stall got=%0b exp=1", StallE); end
    repeat (10) tick();
    checks++; if (StallE !== 1'b1) begin failures++; $display("FAIL div_busy10_stall got=%0b exp=1", StallE); end
    FlushE = 1; #1;
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL flush_stall_comb got=%0b exp=0", StallE); end
    tick();
    checks++; if (ValidM !== 1'b0 || RegWriteM !== 1'b0) begin
      failures++; $display("FAIL flush_bubble got=v%0b w%0b exp=v0 w0", ValidM, RegWriteM);
    end
    clear_inputs(); #1;
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL flush_fsm_idle got=stall%0b exp=stall0", StallE); end
    ValidE = 1; RegWriteE = 1; RD1_E = 2; RD2_E = 3; ALUControlE = 4'd0; #1;
    checks++; if (StallE !== 1'b0) begin failures++; $display("FAIL post_flush_add_stall got=%0b exp=0", StallE); end
    tick();
    checks++; if (ALU_ResultM !== 32'd5 || ValidM !== 1'b1) begin
      failures++; $display("FAIL post_flush_add got=%h v%0b exp=00000005 v1", ALU_ResultM, ValidM);
    end
    clear_inputs();
  endtask

  task automatic test_store_fwd();
    clear_inputs();
    ValidE = 1; RegWriteE = 1; RD1_E = 32'hDEAD; RD2_E = 0; ALUControlE = 4'd0;
    tick();
    checks++; if (ALU_ResultM !== 32'hDEAD) begin failures++; $display("FAIL store_setup got=%h exp=0000dead", ALU_ResultM); end
    RegWriteE = 0; MemWriteE = 1; ALUSrcE = 1; Imm_Ext_E = 32'h8; ForwardB_E = 2'b10;
    RD2_E = 32'h1111; RD1_E = 32'h100;
    tick();
    checks++; if (WriteDataM !== 32'hDEAD || ALU_ResultM !== 32'h108 || MemWriteM !== 1'b1) begin
      failures++; $display("FAIL store_fwd got=wd%h addr%h mw%0b exp=wd0000dead addr00000108 mw1", WriteDataM, ALU_ResultM, MemWriteM);
    end
    ForwardB_E = 2'b11;
    tick();
    checks++; if (WriteDataM !== 32'h1111) begin failures++; $display("FAIL store_fwd11 got=%h exp=00001111", WriteDataM); end
    ValidE = 0;
    tick();
    checks++; if (ValidM !== 1'b0 || MemWriteM !== 1'b0 || WriteDataM !== 32'h0) begin
      failures++; $display("FAIL invalid_bubble got=v%0b mw%0b wd%h exp=v0 mw0 wd0", ValidM, MemWriteM, WriteDataM);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_mul();
    bit wb_seen;
    clear_inputs();
    ValidE = 1; RegWriteE = 1; RD1_E = 1; RD2_E = 2; PCPlus4E = 32'h44;
    tick();
    checks++; if (ValidM !== 1'b1 || PCPlus4M !== 32'h44) begin
      failures++; $display("FAIL pre_reset_valid got=v%0b pc4=%h exp=v1 pc4=00000044", ValidM, PCPlus4M);
    end
    #2 rst = 1; #1;
    checks++; if (ValidM !== 1'b0 || PCPlus4M !== 32'h0 || ALU_ResultM !== 32'h0 || RegWriteM !== 1'b0) begin
      failures++; $display("FAIL async_reset_m got=v%0b pc4=%h alu=%h w%0b exp=all0", ValidM, PCPlus4M, ALU_ResultM, RegWriteM);
    end
    tick();
    rst = 0;
    clear_inputs();
    ValidE = 1; RegWriteE = 1; MduE = 1; MduOpE = 3'b000; RD1_E = 6; RD2_E = 7;
    repeat (5) tick();
    checks++; if (StallE !== 1'b1) begin failures++; $display("FAIL mul_busy_stall got=%0b exp=1", StallE); end
    #2 rst = 1; #1;
    checks++; if (StallE !== 1'b0 || ValidM !== 1'b0 || ALU_ResultM !== 32'h0) begin
      failures++; $display("FAIL reset_mid_mul got=stall%0b v%0b alu=%h exp=stall0 v0 alu0", StallE, ValidM, ALU_ResultM);
    end
    clear_inputs();
    tick();
    rst = 0;
    wb_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ValidM !== 1'b0 || StallE !== 1'b0) wb_seen = 1;
    end
    checks++; if (wb_seen) begin failures++; $display("FAIL abandoned_mul got=writeback_or_stall exp=none"); end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    tick();
    tick();
    test_reset();
    rst = 0;
    test_add_fwd();
    test_alu_ops();
    test_branch();
    test_mulh();
    test_mdu_ops();
    test_flush_mid_div();
    test_store_fwd();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/execute_stage_mdu.md
Name: execute_stage_mdu

Overview:
- Parametrised next-generation RISC-V execute stage: forwarding, extended ALU, full branch-condition evaluation, JAL/JALR target generation, EX/MEM pipeline register.
- Adds an iterative multiply/divide unit (RV32M) that stalls the pipeline, plus valid/flush bubble handling.
- Sits between the decode stage's ID/EX register and the memory stage.
- Drives the stall back to the hazard unit.

Parameters:
XLEN, 32, datapath width (power of two, ≥8)
RA_W, 5, register-address width
MDU_EN, 1, 1 = multiply/divide unit present; 0 = MduE ignored and treated as a normal ALU op

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
ValidE  in  1  instruction in EX is real
FlushE  in  1  kill instruction in EX
RegWriteE, MemWriteE, ResultSrcE, ALUSrcE  in  1 each  decode controls
BranchE, JumpE, JalrE  in  1 each  control-flow type
BranchTypeE  in  3  funct3 of branch
ALUControlE  in  4  ALU op
MduE  in  1  M-extension instruction
MduOpE  in  3  funct3 of M instruction
RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  in  XLEN  operands / PC
RD_E  in  RA_W  destination register
ForwardA_E, ForwardB_E  in  2  forward select
ResultW  in  XLEN  writeback result
PCSrcE  out  1  redirect fetch
PCTargetE  out  XLEN  redirect address
StallE  out  1  hold IF/ID/EX
ValidM, RegWriteM, MemWriteM, ResultSrcM  out  1 each  EX/MEM controls
RD_M  out  RA_W  EX/MEM destination
ALU_ResultM, WriteDataM, PCPlus4M  out  XLEN  EX/MEM data

Behaviour:

Forwarding:
- Select encoding for both muxes: 00 = RDx_E, 01 = ResultW, 10 = ALU_ResultM, 11 = same as 00.
- SrcA = forwarded rs1.
- FwdB = forwarded rs2.
- SrcB = ALUSrcE ? Imm_Ext_E : FwdB.
- Store data: WriteDataM captures FwdB, never the immediate.

ALU (combinational, all results mod 2^XLEN):
- 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt (signed), 6 sltu, 7 sll, 8 srl, 9 sra, 10 pass SrcB.
- Shift amount = SrcB[log2(XLEN)-1:0].
- Codes 11–15 yield 0.

Branch condition (on SrcA, FwdB):
- 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu; 010/011 never taken.
- PCTargetE = JalrE ? (SrcA+Imm)&~1 : PCE+Imm.
- PCSrcE = ValidE & ~FlushE & (JumpE | (BranchE & cond)).
- Jumps write PCPlus4 via ResultSrc path; the EX stage does nothing extra for them.

MDU FSM, states IDLE, BUSY, DONE:
- IDLE:
  - On ValidE & MduE & ~FlushE: latch magnitudes and sign info, clear counter, StallE=1, go BUSY.
  - Otherwise StallE=0.
- BUSY:
  - One shift-add (mul) or restoring-subtract (div) step per cycle; StallE=1.
  - After XLEN steps go DONE.
- DONE:
  - Sign-corrected result selected, StallE=0; EX/MEM captures it at this edge; go IDLE.
- Total StallE high = XLEN+1 cycles. The instruction completes on cycle XLEN+2 after entering EX.
- Upstream inputs are held stable by the hazard unit during the stall.
- MULH/MULHSU/MULHU return the upper XLEN bits of the 2·XLEN product; MUL returns the lower.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (MIN / −1): quotient = MIN, remainder = 0.
- Latency is fixed; there is no early-out.

EX/MEM register:
- Loads every cycle.
- While StallE=1 or FlushE=1 or ValidE=0: load a bubble (ValidM=RegWriteM=MemWriteM=0, data fields don't care but driven 0).
- ALU_ResultM = MDU result for M ops, ALU result otherwise.

Flush:
- FlushE in any state forces FSM to IDLE and inserts a bubble at the next edge.
- StallE is combinationally 0 while FlushE=1.
- Flush has priority over MDU start/completion.

Reset:
- Asynchronous; all M outputs 0, FSM IDLE, counter 0.
- StallE=0 and PCSrcE=0 (given ValidE=0) immediately.
- Reset mid-MDU abandons the operation with no writeback.

MDU_EN=0: MduE ignored; no stall is ever generated.

Test Plan:
- ADD fwd: RD1_E=5, ResultW=7, ForwardA_E=01, RD2_E=3, ALUSrcE=0, ALU=0 -> next edge ALU_ResultM=10, ValidM=1.
- BLT signed: SrcA=0xFFFFFFFF, FwdB=1, BranchE=1, type 100, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120. Type 110 -> PCSrcE=0.
- MULH: 0x80000000 × 0x80000000 -> StallE high 33 cycles, bubbles on M, then ALU_ResultM=0x40000000, RegWriteM=1.
- DIV edge cases: 7/0 -> quotient 0xFFFFFFFF. REM 7/0 -> 7. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- Flush mid-divide: FlushE pulsed in BUSY cycle 10 -> StallE=0 that cycle, ValidM=0 next edge, FSM IDLE; a following ADD completes normally.
- Store forwarding: MemWriteE=1, ALUSrcE=1, ForwardB_E=10, ALU_ResultM=0xDEAD -> WriteDataM=0xDEAD. Async rst asserted mid-MUL -> all M outputs 0, StallE=0 immediately.
